// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared format codes, opcode constants and the opcode-to-format
// helper used by the immediate generator pipeline.
// Optional feature macro: IMM_GEN_CSR_ZIMM_EN (CSR zimm decode, see imm_decode).
package imm_gen_pkg;

    // Immediate format codes carried through the FIFO alongside each result.
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    // RV32I/RV64I major opcodes that carry an immediate.
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Map a major opcode to its immediate format; OP-IMM-32 only exists on RV64.
    function automatic fmt_e opcode_to_fmt(input logic [6:0] opcode, input logic rv64);
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: return FMT_I;
            OP_IMM_32:                           return rv64 ? FMT_I : FMT_NONE;
            OP_STORE:                            return FMT_S;
            OP_BRANCH:                           return FMT_B;
            OP_LUI, OP_AUIPC:                    return FMT_U;
            OP_JAL:                              return FMT_J;
            default:                             return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode: purely combinational instruction -> {format, immediate, illegal}.
// The sign bit is always instruction[31]; the 32-bit immediate is sign-extended
// to XLEN. With IMM_GEN_CSR_ZIMM_EN defined, CSR*I instructions decode as Z
// (zero-extended rs1 field); otherwise they stay I format.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instruction,
    output fmt_e            fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic signed [31:0] imm32;

    // Select the format from the opcode and assemble the 32-bit immediate.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        fmt   = opcode_to_fmt(instruction[6:0], XLEN == 64);
        imm32 = '0;
`ifdef IMM_GEN_CSR_ZIMM_EN
        if (instruction[6:0] == OP_SYSTEM && instruction[14]) begin
            fmt = FMT_Z;
        end
`endif
        case (fmt)
            FMT_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
            FMT_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            FMT_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
            FMT_U: imm32 = {instruction[31:12], 12'd0};
            FMT_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
            FMT_Z: imm32 = {27'd0, instruction[19:15]};
            default: imm32 = '0;
        endcase
    end

    // Size cast of a signed value sign-extends when XLEN is 64.
    assign imm     = XLEN'(imm32);
    assign illegal = (fmt == FMT_NONE);

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator with a DEPTH-entry output FIFO and
// valid/ready handshakes on both sides. Decode happens at the FIFO write port;
// all outputs come from head storage. Optional macro: IMM_GEN_CSR_ZIMM_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              Instruction,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          Imm_out,
    output logic [2:0]               fmt_out,
    output logic                     illegal_out,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    logic [XLEN-1:0]  imm_mem [DEPTH];
    fmt_e             fmt_mem [DEPTH];
    logic             ill_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instruction (Instruction),
        .fmt         (dec_fmt),
        .imm         (dec_imm),
        .illegal     (dec_illegal)
    );

    // in_ready depends only on the registered count, so out_ready never reaches it.
    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count_out = count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Capture the decoded result into the slot at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; head outputs are gated by out_valid, so stale slots are never visible.
        if (push) begin
            imm_mem[wr_ptr] <= dec_imm;
            fmt_mem[wr_ptr] <= dec_fmt;
            ill_mem[wr_ptr] <= dec_illegal;
            tag_mem[wr_ptr] <= in_tag;
        end
    end

    // Head entry drives the outputs; all zero while the FIFO is empty (including during reset).
    assign Imm_out     = out_valid ? imm_mem[rd_ptr] : '0;
    assign fmt_out     = out_valid ? fmt_mem[rd_ptr] : FMT_NONE;
    assign illegal_out = out_valid ? ill_mem[rd_ptr] : 1'b0;
    assign out_tag     = out_valid ? tag_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed + random checks of imm_gen_pipe with a scoreboard.
// Expected results are queued when an instruction is accepted and compared
// when the DUT pops the head. A second XLEN=64 instance covers RV64 extension.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // XLEN=32, DEPTH=2 instance
    logic        in_valid, in_ready, out_valid, out_ready, illegal_out;
    logic [31:0] instruction, in_tag, out_tag, imm_out;
    logic [2:0]  fmt_out;
    logic [1:0]  count_out;

    // XLEN=64 instance
    logic        in_valid64, in_ready64, out_valid64, out_ready64, illegal_out64;
    logic [31:0] instruction64, in_tag64, out_tag64;
    logic [63:0] imm_out64;
    logic [2:0]  fmt_out64;
    logic [1:0]  count_out64;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .Instruction(instruction), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .Imm_out(imm_out), .fmt_out(fmt_out), .illegal_out(illegal_out),
        .out_tag(out_tag), .count_out(count_out)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(32)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .Instruction(instruction64), .in_tag(in_tag64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .Imm_out(imm_out64), .fmt_out(fmt_out64), .illegal_out(illegal_out64),
        .out_tag(out_tag64), .count_out(count_out64)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the ISA encoding tables.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] tag, input bit rv64);
        exp_t        e;
        logic [63:0] v;
        e.tag = tag;
        e.ill = 1'b0;
        e.fmt = 3'd0;
        v     = 64'd0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67: begin e.fmt = 3'd1; v = {{52{w[31]}}, w[31:20]}; end
            7'h73: begin
                e.fmt = 3'd1; v = {{52{w[31]}}, w[31:20]};
`ifdef IMM_GEN_CSR_ZIMM_EN
                if (w[14]) begin e.fmt = 3'd6; v = {59'd0, w[19:15]}; end
`endif
            end
            7'h1B: begin
                if (rv64) begin e.fmt = 3'd1; v = {{52{w[31]}}, w[31:20]}; end
                else      e.ill = 1'b1;
            end
            7'h23: begin e.fmt = 3'd2; v = {{52{w[31]}}, w[31:25], w[11:7]}; end
            7'h63: begin e.fmt = 3'd3; v = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; end
            7'h37, 7'h17: begin e.fmt = 3'd4; v = {{32{w[31]}}, w[31:12], 12'd0}; end
            7'h6F: begin e.fmt = 3'd5; v = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
            default: e.ill = 1'b1;
        endcase
        e.imm = rv64 ? v : {32'd0, v[31:0]};
        return e;
    endfunction

    task automatic drive(input logic [31:0] w, input logic [31:0] tag);
        in_valid    = 1'b1;
        instruction = w;
        in_tag      = tag;
        cur         = model(w, tag, 1'b0);
    endtask

    task automatic drive_exp(input logic [31:0] w, input logic [31:0] tag,
                             input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        in_valid    = 1'b1;
        instruction = w;
        in_tag      = tag;
        cur.imm     = imm;
        cur.fmt     = fmt;
        cur.ill     = ill;
        cur.tag     = tag;
    endtask

    // Called mid-cycle: record what the coming edge will push and check what it will pop.
    task automatic tick();
        exp_t e;
        if (in_valid && in_ready) sb.push_back(cur);
        if (out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow: observed pop with %0d queued, expected >0", sb.size());
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("head_imm", 64'(imm_out), e.imm);
                check("head_fmt", 64'(fmt_out), 64'(e.fmt));
                check("head_ill", 64'(illegal_out), 64'(e.ill));
                check("head_tag", 64'(out_tag), 64'(e.tag));
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h23,
                             7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};

    initial begin
        logic [31:0] r;
        rst           = 1'b1;
        in_valid      = 1'b0;
        instruction   = '0;
        in_tag        = '0;
        out_ready     = 1'b0;
        in_valid64    = 1'b0;
        instruction64 = '0;
        in_tag64      = '0;
        out_ready64   = 1'b0;
        cur           = '{default: '0};

        // Reset state
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(count_out), 64'd0);
        check("rst_imm", 64'(imm_out), 64'd0);
        check("rst_fmt", 64'(fmt_out), 64'd0);
        check("rst_ill", 64'(illegal_out), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single beq, 1-cycle latency
        out_ready = 1'b1;
        drive_exp(32'hFE000EE3, 32'h100, 64'hFFFFFFFC, 3'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        check("latency_valid", 64'(out_valid), 64'd1);
        check("latency_count", 64'(count_out), 64'd1);
        tick();
        check("beq_drained", 64'(count_out), 64'd0);

        // Back-to-back stream, one result per cycle
        drive_exp(32'hFFF00093, 32'h104, 64'hFFFFFFFF, 3'd1, 1'b0);
        tick();
        drive_exp(32'h123450B7, 32'h108, 64'h12345000, 3'd4, 1'b0);
        tick();
        check("stream_count1", 64'(count_out), 64'd1);
        drive_exp(32'h0080006F, 32'h10C, 64'h00000008, 3'd5, 1'b0);
        tick();
        check("stream_count2", 64'(count_out), 64'd1);
        drive_exp(32'h0020A223, 32'h110, 64'h00000004, 3'd2, 1'b0);
        tick();
        check("stream_count3", 64'(count_out), 64'd1);
        in_valid = 1'b0;
        tick();
        check("stream_empty", 64'(out_valid), 64'd0);

        // Fill to DEPTH with back-pressure, illegal entry kept in order
        out_ready = 1'b0;
        drive_exp(32'h00500013, 32'h200, 64'h5, 3'd1, 1'b0);
        tick();
        drive_exp(32'h00000000, 32'h1000, 64'h0, 3'd0, 1'b1);
        tick();
`ifdef IMM_GEN_CSR_ZIMM_EN
        drive_exp(32'h3002D073, 32'h300, 64'h5, 3'd6, 1'b0);
`else
        drive_exp(32'h3002D073, 32'h300, 64'h300, 3'd1, 1'b0);
`endif
        check("full_count", 64'(count_out), 64'd2);
        check("full_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("held_count", 64'(count_out), 64'd2);
        check("held_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop1_count", 64'(count_out), 64'd1);
        check("pop1_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("refill_count", 64'(count_out), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
        check("fill_drained", 64'(sb.size()), 64'd0);
        check("fill_count0", 64'(count_out), 64'd0);

        // Asynchronous reset while full
        out_ready = 1'b0;
        drive(32'h00100093, 32'h400);
        tick();
        tick();
        in_valid = 1'b0;
        check("pre_rst_count", 64'(count_out), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(count_out), 64'd0);
        check("async_rst_ready", 64'(in_ready), 64'd1);
        check("async_rst_imm", 64'(imm_out), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Random mix of opcodes with random back-pressure
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            if ($urandom_range(0, 3) != 0) drive({r[31:7], ops[$urandom_range(0, 11)]}, 32'h8000 + i);
            else                           in_valid = 1'b0;
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
        check("rand_drained", 64'(sb.size()), 64'd0);
        check("rand_count0", 64'(count_out), 64'd0);

        // XLEN=64 sign extension, back-to-back
        out_ready64   = 1'b1;
        in_valid64    = 1'b1;
        instruction64 = 32'hFFF00093;
        in_tag64      = 32'hA0;
        @(posedge clk); #1;
        instruction64 = 32'h800000B7;
        in_tag64      = 32'hA4;
        check("x64_valid", 64'(out_valid64), 64'd1);
        check("x64_addi_imm", imm_out64, 64'hFFFFFFFFFFFFFFFF);
        check("x64_addi_fmt", 64'(fmt_out64), 64'd1);
        check("x64_addi_tag", 64'(out_tag64), 64'hA0);
        @(posedge clk); #1;
        instruction64 = 32'hFFF0009B;
        in_tag64      = 32'hA8;
        check("x64_lui_imm", imm_out64, 64'hFFFFFFFF80000000);
        check("x64_lui_fmt", 64'(fmt_out64), 64'd4);
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        check("x64_addiw_imm", imm_out64, 64'hFFFFFFFFFFFFFFFF);
        check("x64_addiw_fmt", 64'(fmt_out64), 64'd1);
        check("x64_addiw_ill", 64'(illegal_out64), 64'd0);
        @(posedge clk); #1;
        check("x64_empty", 64'(count_out64), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
